// File: rtl/mac_result_commit_if.sv
// Valid/ready bundle between the FMA rounder, the result commit stage and FP writeback.
// The slave modport is the commit stage; the master modport is its environment.
interface mac_result_commit_if #(
    parameter int PARM_EXP  = 8,
    parameter int PARM_MANT = 23,
    parameter int PARM_TAG  = 5
);
    localparam int WORD_W = 1 + PARM_EXP + PARM_MANT;

    logic                 in_valid;
    logic                 in_ready;
    logic                 sign;
    logic [PARM_EXP-1:0]  exponent;
    logic [PARM_MANT-1:0] mantissa;
    logic [PARM_TAG-1:0]  tag;
    logic                 invalid;
    logic                 overflow;
    logic                 underflow;
    logic                 inexact;

    logic                 out_valid;
    logic                 out_ready;
    logic [WORD_W-1:0]    result;
    logic [PARM_TAG-1:0]  out_tag;
    logic [4:0]           fflags;

    modport master (
        output in_valid, sign, exponent, mantissa, tag,
               invalid, overflow, underflow, inexact, out_ready,
        input  in_ready, out_valid, result, out_tag, fflags
    );

    modport slave (
        input  in_valid, sign, exponent, mantissa, tag,
               invalid, overflow, underflow, inexact, out_ready,
        output in_ready, out_valid, result, out_tag, fflags
    );
endinterface

// File: rtl/mac_result_commit.sv
// FMA result commit stage: packs binary32, buffers in a 2-entry skid FIFO, accrues fflags on pop.
// Optional MAC_COMMIT_CANON_NAN_EN: NaNs are replaced by the RISC-V canonical NaN at push.
module mac_result_commit #(
    parameter int PARM_EXP   = 8,
    parameter int PARM_MANT  = 23,
    parameter int PARM_TAG   = 5,
    parameter int PARM_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    mac_result_commit_if.slave bus,
    input  logic               flush,
    input  logic               fflags_wr,
    input  logic [4:0]         fflags_wdata,
    output logic [4:0]         fflags_acc
);
    localparam int WORD_W = 1 + PARM_EXP + PARM_MANT;

    logic [1:0]          count;
    logic                wr_ptr;
    logic                rd_ptr;
    logic [WORD_W-1:0]   slot_word  [PARM_DEPTH];
    logic [PARM_TAG-1:0] slot_tag   [PARM_DEPTH];
    logic [4:0]          slot_flags [PARM_DEPTH];

    logic                not_empty;
    logic                not_full;
    logic                push;
    logic                pop;
    logic [WORD_W-1:0]   push_word;
    logic [4:0]          push_flags;
    logic [4:0]          head_flags;

    // Handshake outputs come from the count register only, keeping inputs off any output path.
    assign not_empty    = (count != 2'd0);
    assign not_full     = (count != 2'd2);
    assign bus.in_ready  = not_full;
    assign bus.out_valid = not_empty;

    assign push = bus.in_valid & not_full;
    assign pop  = bus.out_ready & not_empty;

    // DZ is hard-wired low: a fused multiply-add never divides.
    assign push_flags = {bus.invalid, 1'b0, bus.overflow, bus.underflow, bus.inexact};

`ifdef MAC_COMMIT_CANON_NAN_EN
    localparam logic [WORD_W-1:0] CANON_NAN =
        {1'b0, {PARM_EXP{1'b1}}, 1'b1, {(PARM_MANT-1){1'b0}}};

    logic is_nan;
    assign is_nan    = (&bus.exponent) & (|bus.mantissa);
    assign push_word = is_nan ? CANON_NAN : {bus.sign, bus.exponent, bus.mantissa};
`else
    assign push_word = {bus.sign, bus.exponent, bus.mantissa};
`endif

    assign head_flags  = slot_flags[rd_ptr];
    assign bus.result  = not_empty ? slot_word[rd_ptr] : '0;
    assign bus.out_tag = not_empty ? slot_tag[rd_ptr]  : '0;
    assign bus.fflags  = not_empty ? head_flags        : 5'b0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count      <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fflags_acc <= 5'b0;
        end else begin
            // CSR write lands first; a popped head's flags are ORed on top. Flushed entries never accrue.
            fflags_acc <= (fflags_wr ? fflags_wdata : fflags_acc)
                        | ((pop && !flush) ? head_flags : 5'b0);
            if (flush) begin
                count  <= 2'd0;
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Slot payloads need no reset; they are invisible until count marks them valid.
    always_ff @(posedge clk) begin
        if (rst_n && push && !flush) begin
            slot_word[wr_ptr]  <= push_word;
            slot_tag[wr_ptr]   <= bus.tag;
            slot_flags[wr_ptr] <= push_flags;
        end
    end
endmodule

// File: tb/tb_mac_result_commit.sv
// Directed bench for mac_result_commit with a queue scoreboard and an fflags accrual model.
module tb_mac_result_commit;
    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  tag;
        logic [4:0]  flags;
    } entry_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       fflags_wr;
    logic [4:0] fflags_wdata;
    logic [4:0] fflags_acc;

    entry_t     sb[$];
    logic [4:0] acc_model;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    mac_result_commit_if #(.PARM_EXP(8), .PARM_MANT(23), .PARM_TAG(5)) bus ();

    mac_result_commit #(
        .PARM_EXP(8), .PARM_MANT(23), .PARM_TAG(5), .PARM_DEPTH(2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .flush        (flush),
        .fflags_wr    (fflags_wr),
        .fflags_wdata (fflags_wdata),
        .fflags_acc   (fflags_acc)
    );

    function automatic logic [31:0] pack(input logic s, input logic [7:0] e, input logic [22:0] m);
`ifdef MAC_COMMIT_CANON_NAN_EN
        if (e == 8'hFF && m != 23'd0) return 32'h7FC0_0000;
`endif
        return {s, e, m};
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", name, obs, exp_v);
        end
    endtask

    // fl = {NV, OF, UF, NX}
    task automatic apply_stimulus(input logic v, input logic s, input logic [7:0] e,
                                  input logic [22:0] m, input logic [4:0] t,
                                  input logic [3:0] fl, input logic ordy);
        bus.in_valid  = v;
        bus.sign      = s;
        bus.exponent  = e;
        bus.mantissa  = m;
        bus.tag       = t;
        bus.invalid   = fl[3];
        bus.overflow  = fl[2];
        bus.underflow = fl[1];
        bus.inexact   = fl[0];
        bus.out_ready = ordy;
    endtask

    task automatic check_output();
        check("in_ready",  32'(bus.in_ready),  32'(sb.size() < 2));
        check("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            check("result", bus.result,         sb[0].result);
            check("tag",    32'(bus.out_tag),   32'(sb[0].tag));
            check("fflags", 32'(bus.fflags),    32'(sb[0].flags));
        end else begin
            check("result_empty", bus.result,       32'd0);
            check("tag_empty",    32'(bus.out_tag), 32'd0);
            check("fflags_empty", 32'(bus.fflags),  32'd0);
        end
        check("fflags_acc", 32'(fflags_acc), 32'(acc_model));
    endtask

    // Advance the model by the handshake the driven inputs imply, then cross one edge.
    task automatic tick();
        logic   push, pop;
        logic   [4:0] next_acc;
        entry_t e;
        push = bus.in_valid && (sb.size() < 2);
        pop  = bus.out_ready && (sb.size() != 0);
        if (!rst_n) begin
            sb.delete();
            acc_model = 5'b0;
        end else begin
            next_acc = (fflags_wr ? fflags_wdata : acc_model)
                     | ((pop && !flush) ? sb[0].flags : 5'b0);
            if (flush) begin
                sb.delete();
            end else begin
                if (pop) void'(sb.pop_front());
                if (push) begin
                    e.result = pack(bus.sign, bus.exponent, bus.mantissa);
                    e.tag    = bus.tag;
                    e.flags  = {bus.invalid, 1'b0, bus.overflow, bus.underflow, bus.inexact};
                    sb.push_back(e);
                end
            end
            acc_model = next_acc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        check_output();
        tick();
        flush     = 1'b0;
        fflags_wr = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        flush        = 1'b0;
        fflags_wr    = 1'b0;
        fflags_wdata = 5'b0;
        acc_model    = 5'b0;
        apply_stimulus(1'b0, 1'b0, 8'h0, 23'h0, 5'd0, 4'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;

        $display("[TB] reset state");
        check("rst_out_valid",  32'(bus.out_valid), 32'd0);
        check("rst_in_ready",   32'(bus.in_ready),  32'd1);
        check("rst_result",     bus.result,         32'd0);
        check("rst_fflags_acc", 32'(fflags_acc),    32'd0);

        $display("[TB] single op");
        apply_stimulus(1'b1, 1'b0, 8'h7F, 23'h0, 5'd1, 4'b0001, 1'b1);
        cycle();
        apply_stimulus(1'b0, 1'b0, 8'h0, 23'h0, 5'd0, 4'b0, 1'b1);
        check("single_result", bus.result,       32'h3F80_0000);
        check("single_fflags", 32'(bus.fflags),  32'h01);
        cycle();
        check("single_acc", 32'(fflags_acc), 32'h01);

        $display("[TB] backpressure");
        for (int t = 1; t <= 2; t++) begin
            apply_stimulus(1'b1, t[0], 8'h80 + 8'(t), 23'(t * 1234), 5'(t), 4'(t), 1'b0);
            cycle();
        end
        apply_stimulus(1'b1, 1'b1, 8'h83, 23'h5A5A5, 5'd3, 4'b0010, 1'b0);
        check("bp_full_ready", 32'(bus.in_ready), 32'd0);
        cycle();
        bus.out_ready = 1'b1;
        check("bp_order_1", 32'(bus.out_tag), 32'd1);
        cycle();
        check("bp_order_2", 32'(bus.out_tag), 32'd2);
        cycle();
        bus.in_valid = 1'b0;
        check("bp_order_3", 32'(bus.out_tag), 32'd3);
        cycle();
        cycle();

        $display("[TB] full throughput");
        apply_stimulus(1'b1, 1'b0, 8'h40, 23'h123, 5'd0, 4'b0, 1'b0);
        cycle();
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 254)),
                           23'($urandom), 5'(i + 1), 4'($urandom_range(0, 15)), 1'b1);
            check("tput_in_ready",  32'(bus.in_ready),  32'd1);
            check("tput_out_valid", 32'(bus.out_valid), 32'd1);
            cycle();
        end
        apply_stimulus(1'b0, 1'b0, 8'h0, 23'h0, 5'd0, 4'b0, 1'b1);
        check("tput_last_tag", 32'(bus.out_tag), 32'd16);
        cycle();
        cycle();

        $display("[TB] csr race");
        fflags_wr    = 1'b1;
        fflags_wdata = 5'b10000;
        cycle();
        check("csr_write", 32'(fflags_acc), 32'h10);
        apply_stimulus(1'b1, 1'b0, 8'h90, 23'h7, 5'd7, 4'b0101, 1'b0);
        cycle();
        apply_stimulus(1'b0, 1'b0, 8'h0, 23'h0, 5'd0, 4'b0, 1'b1);
        fflags_wr    = 1'b1;
        fflags_wdata = 5'b00000;
        cycle();
        check("csr_race_acc", 32'(fflags_acc), 32'h05);

        $display("[TB] flush");
        for (int t = 8; t <= 9; t++) begin
            apply_stimulus(1'b1, 1'b0, 8'h70, 23'(t), 5'(t), 4'b1000, 1'b0);
            cycle();
        end
        apply_stimulus(1'b1, 1'b0, 8'h71, 23'h1, 5'd10, 4'b1000, 1'b1);
        flush = 1'b1;
        cycle();
        check("flush_out_valid", 32'(bus.out_valid), 32'd0);
        check("flush_acc",       32'(fflags_acc),    32'h05);
        apply_stimulus(1'b1, 1'b0, 8'h72, 23'h2, 5'd11, 4'b1001, 1'b0);
        cycle();
        apply_stimulus(1'b0, 1'b0, 8'h0, 23'h0, 5'd0, 4'b0, 1'b1);
        flush        = 1'b1;
        fflags_wr    = 1'b1;
        fflags_wdata = 5'b00010;
        cycle();
        check("flush_csr_acc", 32'(fflags_acc), 32'h02);

        $display("[TB] nan handling");
        apply_stimulus(1'b1, 1'b1, 8'hFF, 23'h1, 5'd12, 4'b1000, 1'b0);
        cycle();
`ifdef MAC_COMMIT_CANON_NAN_EN
        check("nan_result", bus.result, 32'h7FC0_0000);
`else
        check("nan_result", bus.result, 32'hFF80_0001);
`endif
        apply_stimulus(1'b1, 1'b1, 8'hFF, 23'h0, 5'd13, 4'b0100, 1'b1);
        cycle();
        apply_stimulus(1'b0, 1'b0, 8'h0, 23'h0, 5'd0, 4'b0, 1'b1);
        check("inf_result", bus.result, 32'hFF80_0000);
        cycle();
        cycle();

        $display("[TB] reset mid-handshake");
        for (int t = 20; t <= 21; t++) begin
            apply_stimulus(1'b1, 1'b0, 8'h33, 23'(t), 5'(t), 4'b0011, 1'b0);
            cycle();
        end
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        apply_stimulus(1'b0, 1'b0, 8'h0, 23'h0, 5'd0, 4'b0, 1'b0);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_acc",       32'(fflags_acc),    32'd0);
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
